seven_seg_capture: RTL

//  Receive-side counterpart of the two-digit multiplexed seven-segment driver. Watches the time-multiplexed

---
 rtl/seven_seg_capture.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/seven_seg_capture.sv
// seven_seg_capture
//   Rebuilds the two-digit pattern from a time-multiplexed seven-segment bus,
//   decodes both digits to hex nibbles, debounces across refresh frames and
//   flags a stale link when digit_sel stops toggling.
// Ports
//   clk        in   1   system clock, all logic on posedge
//   rst        in   1   synchronous, active-high reset
//   segment    in   7   multiplexed pattern {g,f,e,d,c,b,a}, active-high
//   digit_sel  in   1   1: segment holds the high digit, 0: the low digit
//   both7seg   out  14  last published pattern {hi,lo}
//   hex_hi     out  4   decoded high digit
//   hex_lo     out  4   decoded low digit
//   bad_hi     out  1   high pattern not a hex glyph
//   bad_lo     out  1   low pattern not a hex glyph
//   valid      out  1   published data current (link alive, debounced)
//   stale      out  1   no digit_sel toggle for TIMEOUT cycles
//   update     out  1   one-cycle pulse when new data is published
module seven_seg_capture #(
  parameter int STABLE_FRAMES = 2,
  parameter int SBITS         = 3,
  parameter int TIMEOUT       = 400000,
  parameter int TBITS         = 19
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  segment,
  input  logic        digit_sel,
  output logic [13:0] both7seg,
  output logic [3:0]  hex_hi,
  output logic [3:0]  hex_lo,
  output logic        bad_hi,
  output logic        bad_lo,
  output logic        valid,
  output logic        stale,
  output logic        update
);

  localparam logic [SBITS-1:0] MATCH_MAX = '1;
  localparam logic [SBITS-1:0] MATCH_PUB = SBITS'(STABLE_FRAMES);
  localparam logic [TBITS-1:0] IDLE_MAX  = TBITS'(TIMEOUT);

  // Returns {bad, nibble}; unknown glyphs decode to nibble 0 with bad set.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h3F: r = 5'h00;
      7'h06: r = 5'h01;
      7'h5B: r = 5'h02;
      7'h4F: r = 5'h03;
      7'h66: r = 5'h04;
      7'h6D: r = 5'h05;
      7'h7D: r = 5'h06;
      7'h07: r = 5'h07;
      7'h7F: r = 5'h08;
      7'h6F: r = 5'h09;
      7'h77: r = 5'h0A;
      7'h7C: r = 5'h0B;
      7'h39: r = 5'h0C;
      7'h5E: r = 5'h0D;
      7'h79: r = 5'h0E;
      7'h71: r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  logic             sel_q;
  logic [6:0]       hi_cap;
  logic             hi_seen;
  logic [13:0]      cand;
  logic [SBITS-1:0] match;
  logic [TBITS-1:0] idle;

  logic             toggle;
  logic             frame_done;
  logic [13:0]      frame;
  logic [SBITS-1:0] new_match;
  logic             publish;
  logic             idle_hit;
  logic [4:0]       dec_hi;
  logic [4:0]       dec_lo;

  always_comb begin
    toggle     = (digit_sel != sel_q);
    frame      = {hi_cap, segment};
    // A falling edge only closes a frame if its high half was captured
    // since the last reset or stale event.
    frame_done = toggle && !digit_sel && hi_seen;
    if (frame == cand)
      new_match = (match == MATCH_MAX) ? match : match + 1'b1;
    else
      new_match = SBITS'(1);
    // Exact equality: saturated repeats never re-publish.
    publish    = frame_done && (new_match == MATCH_PUB);
    // A toggle on the would-be timeout edge clears the counter instead.
    idle_hit   = !toggle && (idle == IDLE_MAX - 1'b1);
    dec_hi     = decode(hi_cap);
    dec_lo     = decode(segment);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= 1'b0;
      hi_cap   <= '0;
      hi_seen  <= 1'b0;
      cand     <= '0;
      match    <= '0;
      idle     <= '0;
      both7seg <= '0;
      hex_hi   <= '0;
      hex_lo   <= '0;
      bad_hi   <= 1'b0;
      bad_lo   <= 1'b0;
      valid    <= 1'b0;
      stale    <= 1'b0;
      update   <= 1'b0;
    end else begin
      sel_q  <= digit_sel;
      update <= 1'b0;

      if (toggle)
        idle <= '0;
      else if (idle != IDLE_MAX)
        idle <= idle + 1'b1;

      if (toggle && digit_sel) begin
        hi_cap  <= segment;
        hi_seen <= 1'b1;
      end

      if (frame_done) begin
        hi_seen <= 1'b0;
        cand    <= frame;
        match   <= new_match;
      end

      if (publish) begin
        both7seg <= frame;
        hex_hi   <= dec_hi[3:0];
        bad_hi   <= dec_hi[4];
        hex_lo   <= dec_lo[3:0];
        bad_lo   <= dec_lo[4];
        valid    <= 1'b1;
        stale    <= 1'b0;
        update   <= 1'b1;
      end

      // Never coincides with frame_done: one needs a toggle, the other none.
      if (idle_hit) begin
        valid   <= 1'b0;
        stale   <= 1'b1;
        match   <= '0;
        hi_seen <= 1'b0;
      end
    end
  end

endmodule
